uart_rx_8n1: RTL

//  UART receiver, 8 data bits, no parity, 1 stop bit, LSB first.

---
 rtl/uart_rx_8n1.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver, LSB first, with a valid/ready byte output.
// Ports: hwclk, rst_n (async low), ftdi_rx (serial in), rxbyte/rxvalid/rxready
// (byte handshake), frame_err and overrun (1-cycle pulses), busy (not IDLE).
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic       ftdi_rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    input  logic       rxready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             r_sync1;
    logic             r_sync2;
    logic             w_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nx;
    logic [7:0]       r_shreg;
    logic [7:0]       w_shreg_nx;
    logic             w_done;
    logic             w_ferr;
    logic             w_accept;
    logic             w_load;
    logic             w_ovr;

    assign w_rx_s = r_sync2;
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ftdi_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shreg <= w_shreg_nx;
        end
    end

    // The bit timer only runs in START/DATA/STOP and clears at each
    // sample point, so it never needs to wrap.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt + CNT_W'(1);
        w_idx_nx   = r_idx;
        w_shreg_nx = r_shreg;
        w_done     = 1'b0;
        w_ferr     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nx = '0;
                if (!w_rx_s) begin
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (r_cnt == HALF_END) begin
                    w_cnt_nx = '0;
                    w_idx_nx = '0;
                    if (w_rx_s) begin
                        w_state_nx = S_IDLE;
                    end else begin
                        w_state_nx = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nx   = '0;
                    w_shreg_nx = {w_rx_s, r_shreg[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == BIT_END) begin
                    w_cnt_nx = '0;
                    if (w_rx_s) begin
                        w_done     = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_ferr     = 1'b1;
                        w_state_nx = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                w_cnt_nx = '0;
                if (w_rx_s) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: begin
                w_cnt_nx   = '0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    // A completing byte may replace the held one only if that one is
    // being accepted in the same cycle; otherwise it is dropped.
    assign w_accept = rxvalid & rxready;
    assign w_load   = w_done & (~rxvalid | rxready);
    assign w_ovr    = w_done & rxvalid & ~rxready;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            rxbyte    <= 8'h00;
            rxvalid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_ferr;
            overrun   <= w_ovr;
            if (w_load) begin
                rxbyte  <= r_shreg;
                rxvalid <= 1'b1;
            end else if (w_accept) begin
                rxvalid <= 1'b0;
            end
        end
    end

endmodule
